// File: rtl/trace_accumulator.sv
// trace_accumulator: sums 2**NTRACE_LOG2 consecutive TDC traces bin-by-bin
// into an internal RAM, then lets the host read the per-bin sums.
module trace_accumulator #(
   parameter int DEPTH_LOG2  = 10,
   parameter int DATA_W      = 8,
   parameter int NTRACE_LOG2 = 4,
   parameter int ACC_W       = DATA_W + NTRACE_LOG2
) (
   input  logic                   clk_sample,
   input  logic                   rst,
   input  logic                   acc_start,
   input  logic                   mem_we,
   input  logic [12:0]            mem_addr,
   input  logic [DATA_W-1:0]      wave_data,
   output logic                   busy,
   output logic                   done,
   output logic [NTRACE_LOG2:0]   trace_cnt,
   input  logic                   rd_en,
   input  logic [DEPTH_LOG2-1:0]  rd_addr,
   output logic [ACC_W-1:0]       rd_data,
   output logic                   rd_valid
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [NTRACE_LOG2:0] NTRACES = {1'b1, {NTRACE_LOG2{1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCUM,
      ST_FLUSH,
      ST_DONE
   } state_t;

   state_t                  state, state_nx;
   logic                    busy_nx, done_nx;
   logic [NTRACE_LOG2:0]    trace_cnt_nx;
   logic [NTRACE_LOG2:0]    trace_cnt_inc;
   logic                    flush_cnt, flush_cnt_nx;

   logic [ACC_W-1:0]        ram [DEPTH];

   logic [DEPTH_LOG2-1:0]   bin;
   logic                    in_range;
   logic                    sample_take;

   logic                    s1_valid;
   logic [DEPTH_LOG2-1:0]   s1_bin;
   logic [DATA_W-1:0]       s1_data;
   logic                    s1_first;
   logic [ACC_W-1:0]        ram_q;
   logic                    fwd_hit;
   logic [ACC_W-1:0]        fwd_val;
   logic [ACC_W-1:0]        old_val;
   logic [ACC_W-1:0]        sum;

   assign bin           = mem_addr[DEPTH_LOG2-1:0];
   assign in_range      = (mem_addr[12:DEPTH_LOG2] == '0);
   assign sample_take   = mem_we && in_range && ((state == ST_WAIT) || (state == ST_ACCUM));
   assign trace_cnt_inc = trace_cnt + 1'b1;

   // The first trace of a run overwrites the bin; later traces add to the (possibly forwarded) old sum
   assign old_val = fwd_hit ? fwd_val : ram_q;
   assign sum     = (s1_first ? '0 : old_val) + {{(ACC_W-DATA_W){1'b0}}, s1_data};

   // Next-state and next-status logic for the run-control FSM
   always_comb begin
      state_nx     = state;
      busy_nx      = busy;
      done_nx      = done;
      trace_cnt_nx = trace_cnt;
      flush_cnt_nx = flush_cnt;
      case (state)
         ST_IDLE: begin
            if (acc_start) begin
               state_nx     = ST_WAIT;
               busy_nx      = 1'b1;
               trace_cnt_nx = '0;
            end
         end
         ST_WAIT: begin
            if (mem_we) begin
               state_nx = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (!mem_we) begin
               trace_cnt_nx = trace_cnt_inc;
               if (trace_cnt_inc == NTRACES) begin
                  state_nx     = ST_FLUSH;
                  flush_cnt_nx = 1'b0;
               end else begin
                  state_nx = ST_WAIT;
               end
            end
         end
         ST_FLUSH: begin
            if (flush_cnt) begin
               state_nx = ST_DONE;
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
            end else begin
               flush_cnt_nx = 1'b1;
            end
         end
         ST_DONE: begin
            if (acc_start) begin
               state_nx     = ST_WAIT;
               done_nx      = 1'b0;
               busy_nx      = 1'b1;
               trace_cnt_nx = '0;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // FSM state and status registers
   always_ff @(posedge clk_sample) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         trace_cnt <= '0;
         flush_cnt <= 1'b0;
      end else begin
         state     <= state_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         trace_cnt <= trace_cnt_nx;
         flush_cnt <= flush_cnt_nx;
      end
   end

   // Pipeline stage 1 control; a hit on the bin stage 2 is writing captures its fresh sum
   always_ff @(posedge clk_sample) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_bin   <= '0;
         s1_data  <= '0;
         s1_first <= 1'b0;
         fwd_hit  <= 1'b0;
         fwd_val  <= '0;
      end else begin
         s1_valid <= sample_take;
         s1_bin   <= bin;
         s1_data  <= wave_data;
         s1_first <= (trace_cnt == '0);
         fwd_hit  <= s1_valid && (s1_bin == bin);
         fwd_val  <= sum;
      end
   end

   // Accumulator RAM: stage 1 read, stage 2 write
   always_ff @(posedge clk_sample) begin
      ram_q <= ram[bin];
      if (s1_valid) begin
         ram[s1_bin] <= sum;
      end
   end

   // Host readout port, only open once the run is done
   always_ff @(posedge clk_sample) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (rd_en && (state == ST_DONE)) begin
            rd_data  <= ram[rd_addr];
            rd_valid <= 1'b1;
         end
      end
   end

endmodule
